// File: rtl/f100l_fetch_unit_if.sv
// Signal bundle between the F100-L fetch unit, the program ROM, the redirect
// source and the decoder. The master modport is the fetch unit's view.
interface f100l_fetch_unit_if;
  logic [9:0]  rom_address;
  logic [15:0] rom_data;
  logic        redirect;
  logic [9:0]  redirect_address;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [15:0] instr_operand;
  logic        instr_has_operand;
  logic [9:0]  instr_pc;
  logic        fetch_stopped;

  modport master (
    output rom_address,
    input  rom_data,
    input  redirect,
    input  redirect_address,
    output instr_valid,
    input  instr_ready,
    output instr_word,
    output instr_operand,
    output instr_has_operand,
    output instr_pc,
    output fetch_stopped
  );

  modport slave (
    input  rom_address,
    output rom_data,
    output redirect,
    output redirect_address,
    input  instr_valid,
    output instr_ready,
    input  instr_word,
    input  instr_operand,
    input  instr_has_operand,
    input  instr_pc,
    input  fetch_stopped
  );
endinterface

// File: rtl/f100l_fetch_unit.sv
// F100-L instruction fetch: walks the program ROM, assembles 1/2-word
// instructions and queues them for the decoder over valid/ready.
module f100l_fetch_unit #(
  parameter int         DEPTH    = 2,
  parameter logic [9:0] RESET_PC = 10'h000
) (
  input logic               clk,
  input logic               reset,
  f100l_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FETCH_OP      = 2'd0,
    FETCH_OPERAND = 2'd1,
    STOPPED       = 2'd2
  } state_t;

  function automatic logic is_two_word(input logic [15:0] w);
    return (w[15:12] != 4'h0) && (w[10:0] == 11'h000);
  endfunction

  function automatic logic is_halt(input logic [15:0] w);
    return (w[15:12] == 4'h0) && (w[11:10] == 2'b01);
  endfunction

  state_t             state, state_nxt;
  logic [9:0]         pc, pc_nxt;

  // Opcode of a 2-word instruction waiting for its operand word
  logic [15:0]        opcode_p0;
  logic [9:0]         op_pc_p0;

  logic [9:0]         q_pc      [DEPTH];
  logic [15:0]        q_word    [DEPTH];
  logic [15:0]        q_operand [DEPTH];
  logic               q_has_op  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               full, pop, room;
  logic               latch_op, enq;
  logic [9:0]         enq_pc;
  logic [15:0]        enq_word, enq_operand;
  logic               enq_has_op;
  logic               head_vld;

  assign full     = (count == CNT_W'(DEPTH));
  assign head_vld = (count != '0);
  assign pop      = head_vld & bus.instr_ready;
  assign room     = !full || pop;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    latch_op    = 1'b0;
    enq         = 1'b0;
    enq_pc      = pc;
    enq_word    = bus.rom_data;
    enq_operand = '0;
    enq_has_op  = 1'b0;
    if (bus.redirect) begin
      state_nxt = FETCH_OP;
      pc_nxt    = bus.redirect_address;
    end else begin
      case (state)
        FETCH_OP: begin
          if (room) begin
            pc_nxt = pc + 10'd1;
            if (is_two_word(bus.rom_data)) begin
              latch_op  = 1'b1;
              state_nxt = FETCH_OPERAND;
            end else begin
              enq = 1'b1;
              if (is_halt(bus.rom_data)) state_nxt = STOPPED;
            end
          end
        end
        FETCH_OPERAND: begin
          if (room) begin
            enq         = 1'b1;
            enq_pc      = op_pc_p0;
            enq_word    = opcode_p0;
            enq_operand = bus.rom_data;
            enq_has_op  = 1'b1;
            pc_nxt      = pc + 10'd1;
            state_nxt   = FETCH_OP;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state: fetch FSM, pc and queue bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH_OP;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (bus.redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({enq, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Datapath storage: only ever read behind a valid control state
  always_ff @(posedge clk) begin
    if (latch_op) begin
      opcode_p0 <= bus.rom_data;
      op_pc_p0  <= pc;
    end
    if (enq) begin
      q_pc[wr_ptr]      <= enq_pc;
      q_word[wr_ptr]    <= enq_word;
      q_operand[wr_ptr] <= enq_operand;
      q_has_op[wr_ptr]  <= enq_has_op;
    end
  end

  assign bus.rom_address       = pc;
  assign bus.fetch_stopped     = (state == STOPPED);
  assign bus.instr_valid       = head_vld;
  assign bus.instr_pc          = head_vld ? q_pc[rd_ptr]      : '0;
  assign bus.instr_word        = head_vld ? q_word[rd_ptr]    : '0;
  assign bus.instr_operand     = head_vld ? q_operand[rd_ptr] : '0;
  assign bus.instr_has_operand = head_vld ? q_has_op[rd_ptr]  : 1'b0;

endmodule
